// File: rtl/dnn_layer_engine.sv
// Time-multiplexed fully-connected layer: buffers one streamed input vector, then evaluates each
// neuron through a single MAC with bias, rounding, saturation, optional ReLU and running argmax.
module dnn_layer_engine #(
    parameter int unsigned IN_SIZE   = 784,
    parameter int unsigned NEURONS   = 10,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned ACC_W     = 40,
    localparam int unsigned AW = (NEURONS * IN_SIZE > 1) ? $clog2(NEURONS * IN_SIZE) : 1,
    localparam int unsigned NW = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              relu_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [AW-1:0]     w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [NW-1:0]     b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [NW-1:0]     out_idx,
    output logic [NW-1:0]     argmax_idx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int unsigned PW = 2 * DATA_W;
    localparam int unsigned SW = ACC_W + 1;
    localparam logic [IW-1:0] LastI = IW'(IN_SIZE - 1);
    localparam logic [NW-1:0] LastN = NW'(NEURONS - 1);
    localparam logic signed [SW-1:0] SatMax = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] SatMin = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StLoad, StMac, StBias, StOut, StDone} state_e;

    state_e                   state_q, state_d;
    logic [DATA_W-1:0]        vec_q [IN_SIZE];
    logic                     vec_we;
    logic [IW-1:0]            cnt_q, cnt_d, i_q, i_d, rd_i_q, rd_i_d;
    logic                     issued_q, issued_d, rd_v_q, rd_v_d, relu_q, relu_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [NW-1:0]            n_q, n_d, out_idx_q, out_idx_d, argmax_q, argmax_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d, best_q, best_d;
    logic [AW-1:0]            w_addr_q, w_addr_d;
    logic                     in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic                     busy_q, busy_d, done_q, done_d;

    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [SW-1:0]     bias_ext, sum, shr;
    logic [DATA_W-1:0]        res;

    // Weight data returns one cycle after its address, so the product pairs w_data with the
    // buffer index issued on the previous cycle.
    always_comb begin
        prod     = PW'($signed(vec_q[rd_i_q])) * PW'($signed(w_data));
        prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
        bias_ext = {{(SW-DATA_W){b_data[DATA_W-1]}}, b_data};
        sum      = {acc_q[ACC_W-1], acc_q} + (bias_ext <<< FRAC_BITS)
                   + (SW'(1) <<< (FRAC_BITS - 1));
        shr      = sum >>> FRAC_BITS;
        if (shr > SatMax) begin
            res = SatMax[DATA_W-1:0];
        end else if (shr < SatMin) begin
            res = SatMin[DATA_W-1:0];
        end else begin
            res = shr[DATA_W-1:0];
        end
        if (relu_q && res[DATA_W-1]) begin
            res = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        vec_we      = 1'b0;
        cnt_d       = cnt_q;
        i_d         = i_q;
        rd_i_d      = rd_i_q;
        rd_v_d      = 1'b0;
        issued_d    = issued_q;
        relu_d      = relu_q;
        acc_d       = rd_v_q ? acc_q + prod_ext : acc_q;
        n_d         = n_q;
        out_idx_d   = out_idx_q;
        argmax_d    = argmax_q;
        out_data_d  = out_data_q;
        best_d      = best_q;
        w_addr_d    = w_addr_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    relu_d     = relu_en;
                    cnt_d      = '0;
                    n_d        = '0;
                    argmax_d   = '0;
                    best_d     = '0;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    vec_we = 1'b1;
                    cnt_d  = cnt_q + IW'(1);
                    if (cnt_q == LastI) begin
                        in_ready_d = 1'b0;
                        i_d        = '0;
                        issued_d   = 1'b0;
                        acc_d      = '0;
                        w_addr_d   = '0;
                        state_d    = StMac;
                    end
                end
            end
            StMac: begin
                if (!issued_q) begin
                    rd_v_d = 1'b1;
                    rd_i_d = i_q;
                    if (i_q == LastI) begin
                        issued_d = 1'b1;
                    end else begin
                        i_d      = i_q + IW'(1);
                        w_addr_d = w_addr_q + AW'(1);
                    end
                end else begin
                    state_d = StBias;
                end
            end
            StBias: begin
                out_data_d  = res;
                out_idx_d   = n_q;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (n_q == '0 || $signed(out_data_q) > $signed(best_q)) begin
                        best_d   = out_data_q;
                        argmax_d = n_q;
                    end
                    if (n_q == LastN) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        n_d      = n_q + NW'(1);
                        i_d      = '0;
                        issued_d = 1'b0;
                        acc_d    = '0;
                        w_addr_d = w_addr_q + AW'(1);
                        state_d  = StMac;
                    end
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Every entry is written before it is read, so the buffer carries no reset.
    always_ff @(posedge clk) begin
        if (vec_we) begin
            vec_q[cnt_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            i_q         <= '0;
            rd_i_q      <= '0;
            rd_v_q      <= 1'b0;
            issued_q    <= 1'b0;
            relu_q      <= 1'b0;
            acc_q       <= '0;
            n_q         <= '0;
            out_idx_q   <= '0;
            argmax_q    <= '0;
            out_data_q  <= '0;
            best_q      <= '0;
            w_addr_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            i_q         <= i_d;
            rd_i_q      <= rd_i_d;
            rd_v_q      <= rd_v_d;
            issued_q    <= issued_d;
            relu_q      <= relu_d;
            acc_q       <= acc_d;
            n_q         <= n_d;
            out_idx_q   <= out_idx_d;
            argmax_q    <= argmax_d;
            out_data_q  <= out_data_d;
            best_q      <= best_d;
            w_addr_q    <= w_addr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign w_addr     = w_addr_q;
    assign b_addr     = n_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_idx    = out_idx_q;
    assign argmax_idx = argmax_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
